key_schedule: RTL
=================

KEY_SCHEDULE -- requirements
Module: key_schedule

Interface
REQ-001 Parameter KEY_W, default 80, master key width (PRESENT-80 only).
REQ-002 Parameter NUM_KEYS, default 32, number of round keys produced (K1..K32).
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 key_load_i  input  1  pulse; captures key_i and starts a new schedule.
REQ-006 key_i  input  80  master key; sampled only when key_load_i=1.
REQ-007 next_i  input  1  request the next round key; single-cycle pulse or held.
REQ-008 round_key_o  output  64  current round key = key register bits [79:16], to the addRoundKey stage ahead of substitution.
REQ-009 round_cnt_o  output  5  index i of the round key on round_key_o (1..31); wraps to 0 when K32 is shown.
REQ-010 key_valid_o  output  1  round_key_o holds a valid Ki.
REQ-011 done_o  output  1  K32 (final whitening key) is on round_key_o.

Function
REQ-012 State machine SHALL have the states IDLE, ACTIVE and DONE; it SHALL reset to IDLE.
REQ-013 IDLE: key_valid_o=0 and done_o=0; next_i is ignored; key_load_i moves to ACTIVE.
REQ-014 On key_load_i, the next edge SHALL load key_reg<=key_i and cnt<=1, with key_valid_o=1, so K1 = key_i[79:16] appears one cycle after the load.
REQ-015 ACTIVE: each cycle with next_i=1 SHALL apply one update step and increment cnt by 1. At most one step per cycle, with 1-cycle latency from next_i to the new key.
REQ-016 Update step, in this order:
- key_reg <= {key_reg[18:0], key_reg[79:19]} (rotate left 61);
- bits [79:76] <= S(bits [79:76]);
- bits [19:15] <= bits [19:15] XOR cnt[4:0], where cnt is the pre-increment value.
REQ-017 S SHALL be the standard PRESENT 4-bit S-box (C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2).
REQ-018 cnt SHALL be 5 bits. The step taken at cnt=31 SHALL produce K32, wrap cnt to 0, and move to DONE.
REQ-019 DONE: done_o=1 and key_valid_o=1; round_key_o holds K32; next_i is ignored and the key register is frozen.
REQ-020 key_load_i in any state, including ACTIVE and simultaneously with next_i, SHALL take priority and restart the schedule from K1 (per REQ-014); done_o clears on the same edge.
REQ-021 round_key_o, round_cnt_o, key_valid_o and done_o SHALL be driven directly from registers, with no combinational path from inputs.

Reset
REQ-022 rst_i=1 SHALL, without waiting for a clock, force:
- state=IDLE, key_reg=0, cnt=0;
- round_key_o=0, round_cnt_o=0, key_valid_o=0, done_o=0.
REQ-023 Reset asserted mid-schedule SHALL abandon the schedule. After release, no key is valid until a new key_load_i.
REQ-024 Inputs SHALL be ignored while rst_i=1.

Structure
REQ-025 Shared package present_pkg SHALL hold:
- KEY_W=80, BLOCK_W=64, NUM_KEYS=32;
- the state enum type (IDLE/ACTIVE/DONE);
- the round-counter typedef (5 bits).
REQ-026 The top-nibble substitution SHALL reuse the existing sbox module as the single sub-module instance; no duplicate S-box table.
REQ-027 The update step SHALL be one combinational next-key function feeding one 80-bit register. There is no unrolled storage of all 32 keys.

Verification
REQ-028 Reset mid-ACTIVE (cnt=7), asynchronous between edges -> all outputs 0 immediately. After release with next_i=1 held, key_valid_o stays 0.
REQ-029 Zero key: load key_i=0 -> K1=0x0000000000000000, round_cnt_o=1. One next_i -> K2=0xC000000000000000, round_cnt_o=2.
REQ-030 Zero key, next_i held high for 31 cycles -> done_o=1 exactly 31 cycles after K1, round_key_o=K32=0x6DAB31744F41D700. A further next_i leaves the output unchanged.
REQ-031 key_load_i and next_i together at cnt=10 with key_i=0xFFFF_FFFF_FFFF_FFFF_FFFF -> next output is K1=0xFFFFFFFFFFFFFFFF with round_cnt_o=1; no step is applied.
REQ-032 Random 80-bit keys, with next_i gapped randomly -> every Ki matches a reference-model key schedule, and cnt advances only on cycles where next_i=1.

Source files
------------

// File: rtl/present_pkg.sv
// rtl/present_pkg.sv - shared PRESENT-80 widths, key-schedule state and round-counter types
package present_pkg;

  localparam int KEY_W    = 80;
  localparam int BLOCK_W  = 64;
  localparam int NUM_KEYS = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } ks_state_e;

  typedef logic [4:0] round_cnt_t;

endpackage

// File: rtl/sbox.sv
// rtl/sbox.sv - PRESENT 4-bit substitution box
module sbox (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  always_comb begin
    nib_o = 4'h0;
    case (nib_i)
      4'h0: nib_o = 4'hC;
      4'h1: nib_o = 4'h5;
      4'h2: nib_o = 4'h6;
      4'h3: nib_o = 4'hB;
      4'h4: nib_o = 4'h9;
      4'h5: nib_o = 4'h0;
      4'h6: nib_o = 4'hA;
      4'h7: nib_o = 4'hD;
      4'h8: nib_o = 4'h3;
      4'h9: nib_o = 4'hE;
      4'hA: nib_o = 4'hF;
      4'hB: nib_o = 4'h8;
      4'hC: nib_o = 4'h4;
      4'hD: nib_o = 4'h7;
      4'hE: nib_o = 4'h1;
      4'hF: nib_o = 4'h2;
      default: nib_o = 4'h0;
    endcase
  end

endmodule

// File: rtl/key_schedule.sv
// rtl/key_schedule.sv - PRESENT-80 round-key generator, one 80-bit key register stepped per next_i
module key_schedule
  import present_pkg::*;
#(
  parameter int KEY_W    = 80,
  parameter int NUM_KEYS = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               key_load_i,
  input  logic [KEY_W-1:0]   key_i,
  input  logic               next_i,
  output logic [BLOCK_W-1:0] round_key_o,
  output round_cnt_t         round_cnt_o,
  output logic               key_valid_o,
  output logic               done_o
);

  localparam round_cnt_t LAST_CNT = round_cnt_t'(NUM_KEYS - 1);

  ks_state_e          state_q, state_d;
  logic [KEY_W-1:0]   key_q, key_d;
  round_cnt_t         cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;

  logic [KEY_W-1:0]   key_rot;
  logic [KEY_W-1:0]   key_step;
  logic [3:0]         sbox_out;

  assign key_rot = {key_q[18:0], key_q[KEY_W-1:19]};

  sbox u_sbox (
    .nib_i (key_rot[KEY_W-1 -: 4]),
    .nib_o (sbox_out)
  );

  // The counter XOR uses the pre-increment round index.
  assign key_step = {sbox_out, key_rot[KEY_W-5:20], key_rot[19:15] ^ cnt_q, key_rot[14:0]};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    done_d  = done_q;
    if (key_load_i) begin
      state_d = ACTIVE;
      key_d   = key_i;
      cnt_d   = round_cnt_t'(1);
      valid_d = 1'b1;
      done_d  = 1'b0;
    end else if (state_q == ACTIVE && next_i) begin
      key_d = key_step;
      cnt_d = cnt_q + round_cnt_t'(1);
      if (cnt_q == LAST_CNT) begin
        state_d = DONE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign round_key_o = key_q[KEY_W-1 -: BLOCK_W];
  assign round_cnt_o = cnt_q;
  assign key_valid_o = valid_q;
  assign done_o      = done_q;

endmodule
